instr_register_pipe: RTL and testbench
======================================

INSTR_REGISTER_PIPE -- requirements
Module: instr_register_pipe

Interface
REQ-001 SHALL have parameter OP_WIDTH, default 32: signed operand width.
REQ-002 SHALL have parameter DEPTH, default 32: number of entries; AW = $clog2(DEPTH), minimum 1.
REQ-003 SHALL have derived width RW = 2*OP_WIDTH for result width; it is not user-overridable.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 Ports (name, direction, width, meaning):
clk  in  1  sole clock, rising edge.
reset  in  1  synchronous, active-high.
load_en  in  1  accept instruction this cycle.
opcode  in  4  opcode_t encoding: ZERO=0, PASSA=1, PASSB=2, ADD=3, SUB=4, MULT=5, DIV=6, MOD=7.
operand_a, operand_b  in  OP_WIDTH  signed operands.
write_pointer  in  AW  target entry.
read_pointer  in  AW  entry to read.
instruction_word  out  4+2*OP_WIDTH+RW  registered {opc, op_a, op_b, res}.
rd_valid  out  1  entry read has been written since reset.
rd_err  out  2  {div_by_zero, illegal_opcode} of entry read.
wr_done  out  1  one-cycle pulse: an entry committed.
valid_count  out  AW+1  number of written entries.

Function
REQ-006 Write pipeline SHALL have 2 stages: at edge k with load_en=1, capture opcode/operands/pointer into stage-1; at edge k+1, commit stage-1 and its computed result into the entry; wr_done=1 for the cycle after edge k+1.
REQ-007 SHALL accept load_en every cycle with no stall; back-to-back loads to the same pointer SHALL commit in order, so the later one wins.
REQ-008 Results SHALL be signed, sign-extended to RW: ZERO->0; PASSA->a; PASSB->b; ADD->a+b; SUB->a-b; MULT->full a*b product.
REQ-009 DIV SHALL truncate toward zero; MOD SHALL take the sign of the dividend (a = (a/b)*b + a%b).
REQ-010 With min-negative a and b=-1, DIV SHALL give +2^(OP_WIDTH-1) and MOD SHALL give 0; no wrap occurs in RW.
REQ-011 DIV or MOD with b=0 SHALL give res=0 and set the entry's div_by_zero=1.
REQ-012 Opcodes 8..15 SHALL give res=0, set illegal_opcode=1, and still commit (opc field holds the raw value).
REQ-013 Each commit SHALL overwrite both error bits of the entry and set its valid bit.
REQ-014 valid_count SHALL increment by 1 on a commit to an entry whose valid bit was 0, and SHALL otherwise hold; it never exceeds DEPTH.
REQ-015 Read SHALL have 1-cycle latency: read_pointer sampled at edge n gives instruction_word, rd_valid and rd_err after edge n.
REQ-016 A read and a commit to the same entry at the same edge SHALL return the pre-commit contents (read-before-write); the new value is visible on the next read.
REQ-017 write_pointer and read_pointer values >= DEPTH (non-power-of-2 DEPTH) SHALL be ignored: no commit and no count change, and the read returns zeros with rd_valid=0.

Reset
REQ-018 With reset=1 at an edge: all entries SHALL be cleared (opc=ZERO, operands=0, res=0, error bits=0, valid bits=0), stage-1 SHALL be invalidated, and instruction_word=0, rd_valid=0, rd_err=0, wr_done=0, valid_count=0.
REQ-019 Reset SHALL override load_en at the same edge; an instruction in stage-1 at reset SHALL never commit, and wr_done SHALL not pulse for it.
REQ-020 The first load SHALL be accepted at the first edge with reset=0.

Verification
REQ-021 Load ADD a=5, b=-7 to ptr 3 at edge k, then read ptr 3 at edge k+2 -> wr_done high after k+1; after k+2, res=-2, rd_valid=1, rd_err=00, valid_count=1.
REQ-022 With OP_WIDTH=32: DIV a=-7, b=2 -> -3; MOD a=-7, b=2 -> -1; DIV a=0x80000000, b=-1 -> +2147483648 in 64 bits; MULT a=b=0x80000000 -> 0x4000000000000000.
REQ-023 DIV a=9, b=0 -> res=0 with rd_err=10; opcode 12 -> res=0 with rd_err=01; valid_count increments for both.
REQ-024 Load all DEPTH entries on consecutive cycles, then rewrite ptr 0 -> valid_count reaches DEPTH and stays there; ptr 0 holds the second value.
REQ-025 Commit to ptr 4 with read of ptr 4 at the same edge -> returns the old value (zeros with rd_valid=0 after reset); the next read returns the new value.
REQ-026 load_en at edge k, reset=1 at edge k+1 -> no wr_done pulse, valid_count=0, and entry reads as zero with rd_valid=0.

Source files
------------

// File: rtl/instr_register_pipe.sv
// Instruction register file with a 2-stage write pipeline (capture, then execute+commit)
// and a registered 1-cycle read port with read-before-write semantics.
module instr_register_pipe #(
   parameter  int OP_WIDTH = 32,
   parameter  int DEPTH    = 32,
   localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int RW       = 2 * OP_WIDTH,
   localparam int IW       = 4 + 2 * OP_WIDTH + RW
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       load_en,
   input  logic [3:0]                 opcode,
   input  logic signed [OP_WIDTH-1:0] operand_a,
   input  logic signed [OP_WIDTH-1:0] operand_b,
   input  logic [AW-1:0]              write_pointer,
   input  logic [AW-1:0]              read_pointer,
   output logic [IW-1:0]              instruction_word,
   output logic                       rd_valid,
   output logic [1:0]                 rd_err,
   output logic                       wr_done,
   output logic [AW:0]                valid_count
);

   typedef enum logic [3:0] {
      OP_ZERO  = 4'd0,
      OP_PASSA = 4'd1,
      OP_PASSB = 4'd2,
      OP_ADD   = 4'd3,
      OP_SUB   = 4'd4,
      OP_MULT  = 4'd5,
      OP_DIV   = 4'd6,
      OP_MOD   = 4'd7
   } opcode_t;

   typedef struct packed {
      logic [3:0]                 opc;
      logic signed [OP_WIDTH-1:0] a;
      logic signed [OP_WIDTH-1:0] b;
      logic signed [RW-1:0]       res;
      logic [1:0]                 err;   // {div_by_zero, illegal_opcode}
      logic                       vld;
   } entry_t;

   localparam logic [AW:0] PTR_LIM = (AW+1)'(DEPTH);

   entry_t                     r_mem [DEPTH];
   logic [1:0]                 r_vld_pipe;   // [0] stage-1 occupied, [1] committed last edge
   logic [3:0]                 r_s1_opc;
   logic signed [OP_WIDTH-1:0] r_s1_a;
   logic signed [OP_WIDTH-1:0] r_s1_b;
   logic [AW-1:0]              r_s1_ptr;
   logic [IW-1:0]              r_iw;
   logic                       r_rd_valid;
   logic [1:0]                 r_rd_err;
   logic [AW:0]                r_cnt;

   logic signed [RW-1:0]       w_ax;
   logic signed [RW-1:0]       w_bx;
   logic signed [RW-1:0]       w_res;
   logic                       w_dz;
   logic                       w_ill;
   logic                       w_commit;
   logic                       w_rd_ok;

   // Operands widened first so MULT is full-width and DIV of min/-1 cannot wrap.
   assign w_ax = {{OP_WIDTH{r_s1_a[OP_WIDTH-1]}}, r_s1_a};
   assign w_bx = {{OP_WIDTH{r_s1_b[OP_WIDTH-1]}}, r_s1_b};

   always_comb begin
      w_res = '0;
      w_dz  = 1'b0;
      w_ill = 1'b0;
      case (r_s1_opc)
         OP_ZERO:  w_res = '0;
         OP_PASSA: w_res = w_ax;
         OP_PASSB: w_res = w_bx;
         OP_ADD:   w_res = w_ax + w_bx;
         OP_SUB:   w_res = w_ax - w_bx;
         OP_MULT:  w_res = w_ax * w_bx;
         OP_DIV: begin
            if (r_s1_b == '0) w_dz  = 1'b1;
            else              w_res = w_ax / w_bx;
         end
         OP_MOD: begin
            if (r_s1_b == '0) w_dz  = 1'b1;
            else              w_res = w_ax % w_bx;
         end
         default:  w_ill = 1'b1;
      endcase
   end

   assign w_commit = r_vld_pipe[0] && ({1'b0, r_s1_ptr} < PTR_LIM);
   assign w_rd_ok  = ({1'b0, read_pointer} < PTR_LIM);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_vld_pipe <= '0;
         r_s1_opc   <= '0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_ptr   <= '0;
         r_iw       <= '0;
         r_rd_valid <= 1'b0;
         r_rd_err   <= '0;
         r_cnt      <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         r_vld_pipe <= {w_commit, load_en};
         if (load_en) begin
            r_s1_opc <= opcode;
            r_s1_a   <= operand_a;
            r_s1_b   <= operand_b;
            r_s1_ptr <= write_pointer;
         end
         if (w_commit) begin
            r_mem[r_s1_ptr] <= '{opc: r_s1_opc, a: r_s1_a, b: r_s1_b, res: w_res,
                                 err: {w_dz, w_ill}, vld: 1'b1};
            if (!r_mem[r_s1_ptr].vld) r_cnt <= r_cnt + (AW+1)'(1);
         end
         // Reads see the array before this edge's commit lands.
         if (w_rd_ok) begin
            r_iw       <= {r_mem[read_pointer].opc, r_mem[read_pointer].a,
                           r_mem[read_pointer].b, r_mem[read_pointer].res};
            r_rd_valid <= r_mem[read_pointer].vld;
            r_rd_err   <= r_mem[read_pointer].err;
         end else begin
            r_iw       <= '0;
            r_rd_valid <= 1'b0;
            r_rd_err   <= '0;
         end
      end
   end

   assign instruction_word = r_iw;
   assign rd_valid         = r_rd_valid;
   assign rd_err           = r_rd_err;
   assign wr_done          = r_vld_pipe[1];
   assign valid_count      = r_cnt;

endmodule

// File: tb/tb_instr_register_pipe.sv
// Randomized + directed scoreboard bench for instr_register_pipe (OP_WIDTH=32, DEPTH=20).
module tb_instr_register_pipe;
   localparam int W  = 32;
   localparam int D  = 20;
   localparam int AW = 5;
   localparam int IW = 4 + 4 * W;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          load_en = 1'b0;
   logic [3:0]    opcode = '0;
   logic [W-1:0]  operand_a = '0;
   logic [W-1:0]  operand_b = '0;
   logic [AW-1:0] write_pointer = '0;
   logic [AW-1:0] read_pointer = '0;
   logic [IW-1:0] instruction_word;
   logic          rd_valid;
   logic [1:0]    rd_err;
   logic          wr_done;
   logic [AW:0]   valid_count;

   instr_register_pipe #(.OP_WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .reset(reset), .load_en(load_en), .opcode(opcode),
      .operand_a(operand_a), .operand_b(operand_b),
      .write_pointer(write_pointer), .read_pointer(read_pointer),
      .instruction_word(instruction_word), .rd_valid(rd_valid), .rd_err(rd_err),
      .wr_done(wr_done), .valid_count(valid_count));

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  opc;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] res;
      logic [1:0]  err;
      bit          vld;
   } ment_t;

   typedef struct {
      logic [IW-1:0] iw;
      bit            rv;
      logic [1:0]    err;
      bit            wd;
      int            cnt;
   } exp_t;

   ment_t      mm [D];
   exp_t       expq [$];
   bit         p_vld;
   logic [3:0] p_opc;
   int         p_a, p_b, p_ptr;
   int         mcnt;
   int         nvec = 0;
   int         nerr = 0;
   bit         done = 0;

   // Spec arithmetic on 64-bit integers; no modelling of the datapath structure.
   function automatic void calc(input logic [3:0] opc, input int a, input int b,
                                output longint r, output logic [1:0] e);
      longint la = a;
      longint lb = b;
      r = 0;
      e = 2'b00;
      case (opc)
         4'd0: r = 0;
         4'd1: r = la;
         4'd2: r = lb;
         4'd3: r = la + lb;
         4'd4: r = la - lb;
         4'd5: r = la * lb;
         4'd6: if (b == 0) e = 2'b10; else r = la / lb;
         4'd7: if (b == 0) e = 2'b10; else r = la % lb;
         default: e = 2'b01;
      endcase
   endfunction

   task automatic step(input bit rst, input bit ld, input logic [3:0] opc,
                       input int a, input int b, input int wp, input int rp);
      exp_t   e;
      longint r;
      logic [1:0] er;
      @(negedge clk);
      reset = rst; load_en = ld; opcode = opc;
      operand_a = a; operand_b = b;
      write_pointer = AW'(wp); read_pointer = AW'(rp);
      e = '{iw: '0, rv: 0, err: 2'b00, wd: 0, cnt: 0};
      if (rst) begin
         for (int i = 0; i < D; i++) mm[i] = '{opc: 0, a: 0, b: 0, res: 0, err: 0, vld: 0};
         mcnt  = 0;
         p_vld = 0;
      end else begin
         if (rp < D) begin
            e.iw  = {mm[rp].opc, mm[rp].a, mm[rp].b, mm[rp].res};
            e.rv  = mm[rp].vld;
            e.err = mm[rp].err;
         end
         e.wd = p_vld && (p_ptr < D);
         if (e.wd) begin
            calc(p_opc, p_a, p_b, r, er);
            if (!mm[p_ptr].vld) mcnt++;
            mm[p_ptr] = '{opc: p_opc, a: p_a, b: p_b, res: r, err: er, vld: 1};
         end
         e.cnt = mcnt;
         p_vld = ld; p_opc = opc; p_a = a; p_b = b; p_ptr = wp;
      end
      expq.push_back(e);
   endtask

   task automatic idle(input int rp);
      step(0, 0, 4'd0, 0, 0, 0, rp);
   endtask

   task automatic ld(input logic [3:0] opc, input int a, input int b, input int wp, input int rp);
      step(0, 1, opc, a, b, wp, rp);
   endtask

   // Monitor: outputs are presented every cycle, one expected entry per edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            nvec++;
            if (instruction_word !== e.iw || rd_valid !== e.rv || rd_err !== e.err ||
                wr_done !== e.wd || valid_count !== (AW+1)'(e.cnt)) begin
               nerr++;
               $display("FAIL vec%0d: got iw=%h rv=%b err=%b wd=%b cnt=%0d, want iw=%h rv=%b err=%b wd=%b cnt=%0d",
                        nvec, instruction_word, rd_valid, rd_err, wr_done, valid_count,
                        e.iw, e.rv, e.err, e.wd, e.cnt);
            end
         end
      end
   end

   initial begin
      #2000000;
      if (!done) begin
         $display("FAIL timeout: got no completion, want completion");
         nerr++;
         $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
         $finish;
      end
   end

   initial begin
      int rp, wp, a, b;
      logic [3:0] opc;
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 4'd3, 1, 1, 2, 2);
      // ADD 5 + -7 to ptr 3, read at k+2
      ld(4'd3, 5, -7, 3, 0);
      idle(3);
      idle(3);
      // signed DIV/MOD/MULT corners
      ld(4'd6, -7, 2, 5, 0);
      ld(4'd7, -7, 2, 6, 0);
      ld(4'd6, 32'h8000_0000, -1, 7, 0);
      ld(4'd5, 32'h8000_0000, 32'h8000_0000, 8, 0);
      ld(4'd7, 32'h8000_0000, -1, 11, 0);
      ld(4'd6, 9, 0, 9, 0);
      ld(4'd12, 3, 4, 10, 0);
      for (int i = 5; i <= 11; i++) idle(i);
      // out-of-range pointers
      ld(4'd3, 1, 2, 25, 25);
      idle(25);
      idle(31);
      // read-before-write on ptr 4
      step(1, 0, 0, 0, 0, 0, 0);
      ld(4'd1, 77, 0, 4, 4);
      idle(4);
      idle(4);
      // reset kills a load in stage-1
      ld(4'd2, 0, 55, 6, 0);
      step(1, 0, 0, 0, 0, 0, 6);
      idle(6);
      idle(6);
      // fill every entry, rewrite ptr 0
      for (int i = 0; i < D; i++) ld(4'd1, i + 100, 0, i, i);
      ld(4'd1, 999, 0, 0, 0);
      idle(0);
      idle(0);
      idle(D - 1);
      // random traffic
      for (int n = 0; n < 3000; n++) begin
         rp  = int'($urandom_range(0, 31));
         wp  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, D - 1));
         opc = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) opc = 4'($urandom_range(5, 7));
         a = int'($urandom);
         b = int'($urandom);
         case ($urandom_range(0, 7))
            0: b = 0;
            1: begin a = int'(32'h8000_0000); b = -1; end
            2: b = int'($urandom_range(0, 7)) - 3;
            default: ;
         endcase
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), opc, a, b, wp, rp);
      end
      idle(0);
      @(negedge clk);
      @(negedge clk);
      if (expq.size() != 0) begin
         $display("FAIL drain: got %0d pending, want 0", expq.size());
         nerr++;
      end
      done = 1;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
